// File: rtl/capture_trigger_ctrl.sv
// Multi-channel pre/post-trigger capture controller: circular frame history,
// qualified threshold trigger, and valid/ready readout of the captured window.
module capture_trigger_ctrl #(
    parameter  int CHANNELS           = 4,
    parameter  int DATA_W             = 16,
    parameter  int DEPTH              = 32,
    parameter  int PRE_SAMPLES        = 10,
    parameter  int POST_SAMPLES       = 20,
    parameter  int VALID_COUNT_NEEDED = 4,
    localparam int CW                 = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              abort,
    input  logic [DATA_W-1:0] threshold,
    input  logic [CW-1:0]     trig_chan,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [CW-1:0]     rd_chan,
    output logic              rd_last,
    output logic              busy,
    output logic              triggered,
    output logic              done,
    output logic              frame_err,
    output logic              overrun
);
    localparam int AW      = $clog2(DEPTH);
    localparam int MAW     = (DEPTH * CHANNELS > 1) ? $clog2(DEPTH * CHANNELS) : 1;
    localparam int TOTAL   = (PRE_SAMPLES + POST_SAMPLES) * CHANNELS;
    localparam int TW      = $clog2(TOTAL + 1);
    localparam int CMAX    = (PRE_SAMPLES > POST_SAMPLES) ? PRE_SAMPLES : POST_SAMPLES;
    localparam int FW      = $clog2(CMAX + 1);
    localparam int QW      = $clog2(VALID_COUNT_NEEDED + 1);
    localparam logic [MAW-1:0] CH_M = MAW'(CHANNELS);

    typedef enum logic [2:0] {IDLE, PREFILL, ARMED, POST, READOUT} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     chan_q, chan_d, tchan_q, tchan_d, rd_ch_q, rd_ch_d;
    logic [AW-1:0]     wr_frame_q, wr_frame_d, rd_frame_q, rd_frame_d;
    logic [FW-1:0]     cnt_q, cnt_d;
    logic [QW-1:0]     qual_q, qual_d;
    logic [DATA_W-1:0] tsamp_q, tsamp_d;
    logic [TW-1:0]     iss_q, iss_d;
    logic              pend_q, pend_d, pend_last_q, pend_last_d;
    logic [CW-1:0]     pend_chan_q, pend_chan_d;
    logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CW-1:0]     out_chan_q, out_chan_d;
    logic              trig_q, trig_d, done_q, done_d, ferr_q, ferr_d, ovr_q, ovr_d;

    logic [DATA_W-1:0] mem_q [DEPTH*CHANNELS];
    logic [DATA_W-1:0] mem_rdata_q;

    logic              we, issue, accept, commit, bad, last_chan, qualifies, move;
    logic [MAW-1:0]    waddr, raddr;
    logic [DATA_W-1:0] samp;
    logic [DATA_W:0]   sx, mag;

    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        tchan_d     = tchan_q;
        rd_ch_d     = rd_ch_q;
        wr_frame_d  = wr_frame_q;
        rd_frame_d  = rd_frame_q;
        cnt_d       = cnt_q;
        qual_d      = qual_q;
        tsamp_d     = tsamp_q;
        iss_d       = iss_q;
        pend_d      = pend_q;
        pend_chan_d = pend_chan_q;
        pend_last_d = pend_last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_last_d  = out_last_q;
        trig_d      = trig_q;
        done_d      = 1'b0;
        ferr_d      = ferr_q;
        ovr_d       = ovr_q;
        we          = 1'b0;
        issue       = 1'b0;
        move        = 1'b0;

        last_chan = (chan_q == CW'(CHANNELS - 1));
        accept    = in_valid && (state_q == PREFILL || state_q == ARMED || state_q == POST);
        commit    = accept && in_last && last_chan;
        bad       = accept && (in_last != last_chan);
        waddr     = MAW'(wr_frame_q) * CH_M + MAW'(chan_q);
        raddr     = MAW'(rd_frame_q) * CH_M + MAW'(rd_ch_q);

        // Trigger channel may be the frame's final word, so bypass the latch then.
        samp      = (chan_q == tchan_q) ? in_data : tsamp_q;
        sx        = {samp[DATA_W-1], samp};
        mag       = sx[DATA_W] ? (~sx + 1'b1) : sx;
        qualifies = (mag >= {1'b0, threshold});

        if (accept) begin
            we = 1'b1;
            if (chan_q == tchan_q) tsamp_d = in_data;
            chan_d = (commit || bad) ? '0 : chan_q + 1'b1;
            if (bad) ferr_d = 1'b1;
            if (commit) wr_frame_d = wr_frame_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (arm && !abort) begin
                    state_d    = PREFILL;
                    chan_d     = '0;
                    wr_frame_d = '0;
                    cnt_d      = '0;
                    qual_d     = '0;
                    iss_d      = '0;
                    rd_ch_d    = '0;
                    ferr_d     = 1'b0;
                    ovr_d      = 1'b0;
                    tchan_d    = trig_chan;
                end
            end
            PREFILL: begin
                if (commit) begin
                    if (cnt_q == FW'(PRE_SAMPLES - 1)) begin
                        state_d = ARMED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ARMED: begin
                if (commit) begin
                    if (!qualifies) begin
                        qual_d = '0;
                    end else if (qual_q == QW'(VALID_COUNT_NEEDED - 1)) begin
                        trig_d     = 1'b1;
                        rd_frame_d = wr_frame_q - AW'(PRE_SAMPLES);
                        cnt_d      = FW'(1);
                        state_d    = (POST_SAMPLES == 1) ? READOUT : POST;
                    end else begin
                        qual_d = qual_q + 1'b1;
                    end
                end
            end
            POST: begin
                if (commit) begin
                    if (cnt_q == FW'(POST_SAMPLES - 1)) state_d = READOUT;
                    else                                 cnt_d   = cnt_q + 1'b1;
                end
            end
            READOUT: begin
                if (in_valid) ovr_d = 1'b1;
                // Two-stage pipe: memory read register feeds the output register,
                // and a new read is only issued when the pending word can advance.
                move = pend_q && (!out_valid_q || rd_ready);
                if (out_valid_q && rd_ready) out_valid_d = 1'b0;
                if (move) begin
                    out_valid_d = 1'b1;
                    out_data_d  = mem_rdata_q;
                    out_chan_d  = pend_chan_q;
                    out_last_d  = pend_last_q;
                    pend_d      = 1'b0;
                end
                if (iss_q != TW'(TOTAL) && (!pend_q || move)) begin
                    issue       = 1'b1;
                    pend_d      = 1'b1;
                    pend_chan_d = rd_ch_q;
                    pend_last_d = (iss_q == TW'(TOTAL - 1));
                    iss_d       = iss_q + 1'b1;
                    if (rd_ch_q == CW'(CHANNELS - 1)) begin
                        rd_ch_d    = '0;
                        rd_frame_d = rd_frame_q + 1'b1;
                    end else begin
                        rd_ch_d = rd_ch_q + 1'b1;
                    end
                end
                if (out_valid_q && rd_ready && out_last_q) begin
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    trig_d      = 1'b0;
                    out_valid_d = 1'b0;
                    pend_d      = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d     = IDLE;
            trig_d      = 1'b0;
            out_valid_d = 1'b0;
            pend_d      = 1'b0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            chan_q      <= '0;
            tchan_q     <= '0;
            rd_ch_q     <= '0;
            wr_frame_q  <= '0;
            rd_frame_q  <= '0;
            cnt_q       <= '0;
            qual_q      <= '0;
            tsamp_q     <= '0;
            iss_q       <= '0;
            pend_q      <= 1'b0;
            pend_chan_q <= '0;
            pend_last_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_last_q  <= 1'b0;
            trig_q      <= 1'b0;
            done_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            chan_q      <= chan_d;
            tchan_q     <= tchan_d;
            rd_ch_q     <= rd_ch_d;
            wr_frame_q  <= wr_frame_d;
            rd_frame_q  <= rd_frame_d;
            cnt_q       <= cnt_d;
            qual_q      <= qual_d;
            tsamp_q     <= tsamp_d;
            iss_q       <= iss_d;
            pend_q      <= pend_d;
            pend_chan_q <= pend_chan_d;
            pend_last_q <= pend_last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_last_q  <= out_last_d;
            trig_q      <= trig_d;
            done_q      <= done_d;
            ferr_q      <= ferr_d;
            ovr_q       <= ovr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we)    mem_q[waddr] <= in_data;
        if (issue) mem_rdata_q  <= mem_q[raddr];
    end

    assign rd_valid  = out_valid_q;
    assign rd_data   = out_data_q;
    assign rd_chan   = out_chan_q;
    assign rd_last   = out_last_q;
    assign busy      = (state_q != IDLE);
    assign triggered = trig_q;
    assign done      = done_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
endmodule

// File: tb/tb_capture_trigger_ctrl.sv
// Directed bench for capture_trigger_ctrl: trigger qualification, framing
// errors, wrap-around readout, backpressure, abort and reset behaviour.
module tb_capture_trigger_ctrl;
    localparam int CH   = 4;
    localparam int PRE  = 10;
    localparam int POST = 20;
    localparam int NW   = (PRE + POST) * CH;

    logic        clk = 1'b0, rst = 1'b0, arm = 1'b0, abort = 1'b0;
    logic        in_valid = 1'b0, in_last = 1'b0, rd_ready = 1'b0;
    logic [15:0] threshold = '0, in_data = '0;
    logic [1:0]  trig_chan = '0;
    logic        rd_valid, rd_last, busy, triggered, done, frame_err, overrun;
    logic [15:0] rd_data;
    logic [1:0]  rd_chan;

    int errors = 0;
    int checks = 0;
    logic [15:0] hist [0:255][0:3];
    int nf;

    always #5 clk = ~clk;

    capture_trigger_ctrl #(
        .CHANNELS(CH), .DATA_W(16), .DEPTH(32), .PRE_SAMPLES(PRE),
        .POST_SAMPLES(POST), .VALID_COUNT_NEEDED(4)
    ) dut (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort), .threshold(threshold),
        .trig_chan(trig_chan), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_chan(rd_chan),
        .rd_last(rd_last), .busy(busy), .triggered(triggered), .done(done),
        .frame_err(frame_err), .overrun(overrun)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [15:0] d, input logic l);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
    endtask

    // One well-formed frame followed by a bubble; recorded in the history model.
    task automatic send_frame(input logic [15:0] c0);
        logic [15:0] v;
        for (int c = 0; c < CH; c++) begin
            v = (c == 0) ? c0 : 16'(1000 + nf * 4 + c);
            hist[nf][c] = v;
            send_word(v, c == CH - 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        nf++;
    endtask

    task automatic send_bad();
        send_word(16'h0111, 1'b0);
        send_word(16'h0222, 1'b0);
        send_word(16'h0333, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic arm_cap(input logic [15:0] thr);
        @(negedge clk);
        arm       = 1'b1;
        threshold = thr;
        trig_chan = 2'd0;
        @(negedge clk);
        arm = 1'b0;
        nf  = 0;
    endtask

    task automatic do_abort();
        @(negedge clk);
        abort    = 1'b1;
        rd_ready = 1'b0;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic check_latency();
        check("lat0_valid", rd_valid, 0);
        check("lat0_busy", busy, 1);
        @(negedge clk);
        check("lat1_valid", rd_valid, 0);
        @(negedge clk);
        check("lat2_valid", rd_valid, 1);
    endtask

    task automatic read_all(input int start, input bit toggle, input int stop_after, input bit poke);
        int k = 0;
        int cyc = 0;
        bit held = 1'b0;
        logic [15:0] hd;
        logic [1:0]  hc;
        logic        hl;
        logic [3:0]  pat = 4'b1001;
        int idx;
        while (k < stop_after && cyc < 2000) begin
            @(negedge clk);
            in_valid = poke && (cyc == 3);
            in_data  = 16'hBEEF;
            in_last  = 1'b0;
            if (held) begin
                check("hold_valid", rd_valid, 1);
                check("hold_data", rd_data, hd);
                check("hold_chan", rd_chan, hc);
                check("hold_last", rd_last, hl);
            end
            rd_ready = toggle ? pat[cyc % 4] : 1'b1;
            if (rd_valid && rd_ready) begin
                idx = start + k / CH;
                check($sformatf("rd_data[%0d]", k), rd_data, hist[idx][k % CH]);
                check($sformatf("rd_chan[%0d]", k), rd_chan, k % CH);
                check($sformatf("rd_last[%0d]", k), rd_last, k == NW - 1);
                k++;
                held = 1'b0;
            end else if (rd_valid) begin
                held = 1'b1;
                hd   = rd_data;
                hc   = rd_chan;
                hl   = rd_last;
            end
            cyc++;
        end
        check("rd_count", k, stop_after);
    endtask

    task automatic finish_readout();
        @(negedge clk);
        rd_ready = 1'b0;
        in_valid = 1'b0;
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("done_rd_valid", rd_valid, 0);
        check("done_trig", triggered, 0);
        @(negedge clk);
        check("done_clear", done, 0);
    endtask

    task automatic tail_capture(input logic [15:0] qv);
        for (int i = 0; i < 4; i++) send_frame(qv);
        check("trig_set", triggered, 1);
        for (int i = 0; i < POST - 2; i++) send_frame(qv);
        check("post_busy", busy, 1);
        send_frame(qv);
    endtask

    initial begin
        int done_seen;
        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_done", done, 0);
        check("rst_trig", triggered, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        rst = 1'b1;

        // Ramp capture: below-threshold history, trigger on frame 43.
        arm_cap(16'd32);
        check("arm_busy", busy, 1);
        for (int f = 0; f < 40; f++) send_frame(16'(f & 31));
        check("ramp_no_trig", triggered, 0);
        for (int f = 40; f < 43; f++) send_frame(16'(f));
        check("ramp_pre_trig", triggered, 0);
        send_frame(16'd43);
        check("ramp_trig", triggered, 1);
        for (int f = 44; f < 63; f++) send_frame(16'(f));
        check_latency();
        check("ramp_first_word", rd_data, 16'd1);
        read_all(33, 1'b0, NW, 1'b0);
        finish_readout();

        // Qualification broken by a non-qualifying frame.
        arm_cap(16'd32);
        for (int i = 0; i < PRE; i++) send_frame(16'd0);
        for (int i = 0; i < 3; i++) send_frame(16'd40);
        send_frame(16'd0);
        for (int i = 0; i < 3; i++) send_frame(16'd40);
        check("qual_7th", triggered, 0);
        send_frame(16'd40);
        check("qual_8th", triggered, 1);
        do_abort();
        check("abort_busy", busy, 0);
        check("abort_trig", triggered, 0);

        // Arm and abort together: abort wins.
        @(negedge clk);
        arm   = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        arm   = 1'b0;
        abort = 1'b0;
        check("arm_abort_idle", busy, 0);

        // Negative magnitudes: -31 misses, -32 qualifies.
        arm_cap(16'd32);
        for (int i = 0; i < PRE; i++) send_frame(16'd0);
        for (int i = 0; i < 4; i++) send_frame(16'hFFE1);
        check("neg31_no_trig", triggered, 0);
        for (int i = 0; i < 3; i++) send_frame(16'hFFE0);
        check("neg32_3", triggered, 0);
        send_frame(16'hFFE0);
        check("neg32_trig", triggered, 1);
        do_abort();

        // Most-negative sample: magnitude 32768 without saturation.
        arm_cap(16'h8000);
        for (int i = 0; i < PRE; i++) send_frame(16'd0);
        for (int i = 0; i < 4; i++) send_frame(16'h7FFF);
        check("max_pos_no_trig", triggered, 0);
        for (int i = 0; i < 4; i++) send_frame(16'h8000);
        check("min_neg_trig", triggered, 1);
        do_abort();

        // Frame error, long wrap in ARMED, backpressured readout with overrun.
        arm_cap(16'd32);
        check("arm_clr_ferr", frame_err, 0);
        for (int i = 0; i < PRE; i++) send_frame(16'(nf & 31));
        send_bad();
        check("bad_ferr", frame_err, 1);
        for (int i = 0; i < 100; i++) send_frame(16'(nf & 31));
        check("wrap_no_trig", triggered, 0);
        tail_capture(16'd50);
        check_latency();
        read_all(113 - PRE, 1'b1, NW, 1'b1);
        finish_readout();
        check("wrap_ovr", overrun, 1);
        check("wrap_ferr_sticky", frame_err, 1);

        // Abort mid-readout: no done, sticky flags kept.
        arm_cap(16'd32);
        check("arm_clr_ovr", overrun, 0);
        check("arm_clr_ferr2", frame_err, 0);
        for (int i = 0; i < PRE; i++) send_frame(16'd5);
        tail_capture(16'd60);
        read_all(3, 1'b1, 5, 1'b1);
        do_abort();
        check("rd_abort_busy", busy, 0);
        check("rd_abort_valid", rd_valid, 0);
        check("rd_abort_trig", triggered, 0);
        check("rd_abort_ovr", overrun, 1);
        done_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("rd_abort_no_done", done_seen, 0);

        // Reset during POST, then a clean capture.
        arm_cap(16'd32);
        for (int i = 0; i < PRE; i++) send_frame(16'd1);
        for (int i = 0; i < 7; i++) send_frame(16'd70);
        check("post_trig", triggered, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_trig", triggered, 0);
        check("mrst_valid", rd_valid, 0);
        check("mrst_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        arm_cap(16'd32);
        for (int i = 0; i < PRE; i++) send_frame(16'(i));
        tail_capture(16'hFF00);
        check_latency();
        read_all(3, 1'b0, NW, 1'b0);
        finish_readout();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
